vga_timing_gen: RTL
===================

# vga_timing_gen

Raster timing generator for the 640x480 @ 60 Hz display path. Runs on the pixel clock and produces the horizontal and vertical counters, `DrawX`/`DrawY`, `blank`, and sync pulses consumed by the sprite/palette renderers. It also provides frame and vertical-blank strobes for game-state updates. Sync outputs are delayed so they stay aligned with the renderers' one-cycle registered colour output.

## Interface
- `H_VISIBLE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, horizontal sync width (clocks)
- `H_BP`, 48, horizontal back porch (clocks)
- `V_VISIBLE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_DELAY`, 1, pipeline delay in clocks applied to `hs`/`vs` (0..4)

Ports:
- `vga_clk` in 1: pixel clock. One clock for the whole block; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `DrawX` out 10: current horizontal count, 0..H_TOTAL-1. H_TOTAL = 800 by default.
- `DrawY` out 10: current vertical count, 0..V_TOTAL-1. V_TOTAL = 525 by default.
- `blank` out 1: high while the pixel is visible (DrawX < H_VISIBLE and DrawY < V_VISIBLE). Renderers drive colour only while it is high.
- `hs` out 1: horizontal sync, active-low, delayed by SYNC_DELAY.
- `vs` out 1: vertical sync, active-low, delayed by SYNC_DELAY.
- `frame_start` out 1: one-cycle pulse while the counters are at (0,0).
- `vblank_start` out 1: one-cycle pulse while the counters are at (0,V_VISIBLE).
- `frame_count` out 16: number of completed frames, wraps modulo 2^16.

## Operation
- **Horizontal counter (`hc`)**
  - Increments every clock.
  - At H_TOTAL-1 it wraps to 0 and advances the vertical counter.
- **Vertical counter (`vc`)**
  - At V_TOTAL-1, together with the horizontal wrap, it wraps to 0.
  - At that same edge `frame_count` increments.
- **Counter outputs**
  - `DrawX`=`hc` and `DrawY`=`vc`, driven directly from the registers.
- **Decoded outputs (combinational from the counters, forced 0 while `reset` is high)**
  - `blank`
  - `frame_start`
  - `vblank_start`
- **Raw sync (internal)**
  - Raw hsync is low for hc in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1], default [656,751].
  - Raw vsync is low for vc in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1], default [490,491].
  - Raw syncs are registered once, then pass through a (SYNC_DELAY)-stage shift register.
  - SYNC_DELAY=0 means the registered raw sync drives `hs`/`vs` directly, so there is always at least 1 register.
- **Width rules**
  - H_TOTAL and V_TOTAL must each be ≤1024.
  - Counters are exactly 10 bits.
  - Parameter sums are computed at elaboration; no runtime arithmetic beyond compare and increment.
- **Reset**
  - `hc`=0, `vc`=0, `frame_count`=0.
  - All sync pipeline stages are 1, so `hs`=`vs`=1 (inactive).
  - `blank`=`frame_start`=`vblank_start`=0.
- **Reset asserted mid-frame**
  - All state returns to reset values on the next edge.
  - There are no partial sync pulses beyond those already in the delay pipeline, which are flushed to 1.

## Timing
- First clock after `reset` deasserts:
  - Counters are at (0,0).
  - `frame_start`=1 and `blank`=1.
  - `frame_count`=0.
- Line length is 800 clocks. `blank` is high for clocks 0..639 of lines 0..479.
- `hs` goes low at clock 656 + 1 + SYNC_DELAY of each line (default 658) and stays low 96 clocks. This holds on every line, including vertical blanking lines.
- `vs` goes low at line 490, clock 1+SYNC_DELAY, and stays low for 1600 clocks.
- Frame length is 420000 clocks; `frame_start` recurs with exactly that period.
- `vblank_start` fires once per frame, 384000 clocks after `frame_start`.
- `frame_count` updates on the edge where (799,524) → (0,0). The new value is visible in the same cycle that `frame_start` is high.
- At `frame_count`=16'hFFFF it wraps to 0 at the next frame boundary.

## Test plan
- **Reset hold:** `reset` high 5 clocks → DrawX=0, DrawY=0, hs=1, vs=1, blank=0, frame_start=0, frame_count=0. Deassert → next cycle frame_start=1, blank=1.
- **Line timing:** run 2 lines → blank high exactly 640 clocks per line. With default SYNC_DELAY=1, hs low on clocks 658..753 and high elsewhere. DrawX wraps 799→0 while DrawY increments.
- **Frame timing:** run 2 full frames → frame_start pulses spaced 420000 clocks. vblank_start at (0,480). vs low for exactly 1600 clocks starting line 490, clock 2. frame_count reads 1 then 2.
- **frame_count wrap:** force frame_count to 16'hFFFF via hierarchical deposit, run to the frame boundary → frame_count=0 in the same cycle frame_start=1.
- **Mid-frame reset:** assert `reset` at DrawX=700, DrawY=490 (hs and vs both low) for 1 clock → next edge hs=1, vs=1, counters 0, frame_count=0. Normal timing resumes from (0,0).
- **SYNC_DELAY=3 build:** hs falling edge at clock 660 of each line. The relative alignment of `blank` is unchanged.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, visible-area decode, frame strobes, delayed syncs.
// Latency: counters/decodes immediate; hs/vs lag the counters by 1 + SYNC_DELAY clocks.
// Backpressure: none; free-running on the pixel clock, only reset stalls it.
module vga_timing_gen #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int SYNC_DELAY = 1
) (
   input  logic        vga_clk,
   input  logic        reset,
   output logic [9:0]  DrawX,
   output logic [9:0]  DrawY,
   output logic        blank,
   output logic        hs,
   output logic        vs,
   output logic        frame_start,
   output logic        vblank_start,
   output logic [15:0] frame_count
);

   // Totals must fit the 10-bit counters (each at most 1024).
   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   // All thresholds folded to counter width so the datapath is compare-only.
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

   logic [9:0]            hc_q, hc_d;
   logic [9:0]            vc_q, vc_d;
   logic [15:0]           frame_count_q, frame_count_d;
   // Stage 0 is the registered raw sync; stages 1..SYNC_DELAY are the alignment delay.
   logic [SYNC_DELAY:0]   hs_pipe_q, hs_pipe_d;
   logic [SYNC_DELAY:0]   vs_pipe_q, vs_pipe_d;
   logic                  hs_raw;
   logic                  vs_raw;

   // Next-state for the raster counters and the completed-frame counter.
   always_comb begin
      hc_d          = hc_q + 10'd1;
      vc_d          = vc_q;
      frame_count_d = frame_count_q;
      if (hc_q == H_LAST) begin
         hc_d = '0;
         if (vc_q == V_LAST) begin
            vc_d          = '0;
            frame_count_d = frame_count_q + 16'd1;
         end else begin
            vc_d = vc_q + 10'd1;
         end
      end
   end

   // Raw active-low syncs decoded from the current counters, then shifted down the delay line.
   always_comb begin
      hs_raw       = !((hc_q >= HS_FIRST) && (hc_q <= HS_LAST));
      vs_raw       = !((vc_q >= VS_FIRST) && (vc_q <= VS_LAST));
      hs_pipe_d    = hs_pipe_q;
      vs_pipe_d    = vs_pipe_q;
      hs_pipe_d[0] = hs_raw;
      vs_pipe_d[0] = vs_raw;
      for (int i = 1; i <= SYNC_DELAY; i++) begin
         hs_pipe_d[i] = hs_pipe_q[i-1];
         vs_pipe_d[i] = vs_pipe_q[i-1];
      end
   end

   // State registers; reset flushes the sync pipeline to inactive so no partial pulse escapes.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         hc_q          <= '0;
         vc_q          <= '0;
         frame_count_q <= '0;
         hs_pipe_q     <= '1;
         vs_pipe_q     <= '1;
      end else begin
         hc_q          <= hc_d;
         vc_q          <= vc_d;
         frame_count_q <= frame_count_d;
         hs_pipe_q     <= hs_pipe_d;
         vs_pipe_q     <= vs_pipe_d;
      end
   end

   // Output decode; strobes and visible flag are held low while reset is asserted.
   always_comb begin
      DrawX        = hc_q;
      DrawY        = vc_q;
      frame_count  = frame_count_q;
      hs           = hs_pipe_q[SYNC_DELAY];
      vs           = vs_pipe_q[SYNC_DELAY];
      blank        = !reset && (hc_q < H_VIS) && (vc_q < V_VIS);
      frame_start  = !reset && (hc_q == 10'd0) && (vc_q == 10'd0);
      vblank_start = !reset && (hc_q == 10'd0) && (vc_q == V_VIS);
   end

endmodule
